// File: rtl/uart_tx_frame_packer_if.sv
// Frame-in / byte-out bundle for the UART debug read-back packer.
interface uart_tx_frame_packer_if;
  logic        frame_valid;
  logic [41:0] frame_data;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        overflow;
  logic        clear_overflow;
  logic [15:0] frames_sent;

  // Driver side: frame source, UART transmitter and host diagnostics.
  modport master (
    output frame_valid, frame_data, tx_ready, clear_overflow,
    input  tx_byte, tx_valid, busy, overflow, frames_sent
  );

  // Packer side.
  modport slave (
    input  frame_valid, frame_data, tx_ready, clear_overflow,
    output tx_byte, tx_valid, busy, overflow, frames_sent
  );
endinterface

// File: rtl/uart_tx_frame_packer.sv
// Buffers 42-bit read-back frames in a small FIFO and serializes each into an
// 8-byte packet: sync, {type, addr[8]}, addr[7:0], data MSB first, XOR checksum.
module uart_tx_frame_packer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input logic                    i_clk,
  input logic                    i_reset,
  uart_tx_frame_packer_if.slave  io_bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [AW:0] FullCount = PW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e      r_state, w_state_d;
  logic [2:0]  r_idx, w_idx_d;
  logic [47:0] r_pkt;
  logic [7:0]  r_csum;
  logic [41:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic        r_overflow;
  logic [15:0] r_frames_sent;

  logic [AW:0] w_count;
  logic        w_full, w_empty, w_pop, w_push, w_drop, w_last;
  logic [41:0] w_head;
  logic [7:0]  w_head_csum;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == FullCount);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop   = (r_state == StIdle) && !w_empty;
  // A push into a full FIFO is still taken when the head leaves in the same cycle;
  // the write slot is then the one being vacated.
  assign w_push  = io_bus.frame_valid && (!w_full || w_pop);
  assign w_drop  = io_bus.frame_valid && w_full && !w_pop;
  assign w_last  = (r_state == StSend) && io_bus.tx_ready && (r_idx == 3'd7);

  assign w_head_csum = {6'b0, w_head[41:40]} ^ w_head[39:32] ^ w_head[31:24] ^
                       w_head[23:16] ^ w_head[15:8] ^ w_head[7:0];

  assign io_bus.busy        = (r_state != StIdle) || !w_empty;
  assign io_bus.overflow    = r_overflow;
  assign io_bus.frames_sent = r_frames_sent;

  // Frame storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= io_bus.frame_data;
    end
  end

  // State, packet register, FIFO pointers and diagnostics.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_idx         <= 3'd0;
      r_pkt         <= 48'd0;
      r_csum        <= 8'd0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_overflow    <= 1'b0;
      r_frames_sent <= 16'd0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_pkt    <= {6'b0, w_head};
        r_csum   <= w_head_csum;
      end
      // Set beats clear when both happen together.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (io_bus.clear_overflow) begin
        r_overflow <= 1'b0;
      end
      if (w_last) begin
        r_frames_sent <= r_frames_sent + 16'd1;
      end
    end
  end

  // Next-state, byte index and byte-interface outputs.
  always_comb begin
    w_state_d       = r_state;
    w_idx_d         = r_idx;
    io_bus.tx_valid = 1'b0;
    io_bus.tx_byte  = 8'd0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_state_d = StSend;
          w_idx_d   = 3'd0;
        end
      end
      StSend: begin
        io_bus.tx_valid = 1'b1;
        case (r_idx)
          3'd0:    io_bus.tx_byte = SYNC_BYTE;
          3'd1:    io_bus.tx_byte = r_pkt[47:40];
          3'd2:    io_bus.tx_byte = r_pkt[39:32];
          3'd3:    io_bus.tx_byte = r_pkt[31:24];
          3'd4:    io_bus.tx_byte = r_pkt[23:16];
          3'd5:    io_bus.tx_byte = r_pkt[15:8];
          3'd6:    io_bus.tx_byte = r_pkt[7:0];
          default: io_bus.tx_byte = r_csum;
        endcase
        if (io_bus.tx_ready) begin
          if (r_idx == 3'd7) begin
            w_state_d = StIdle;
          end else begin
            w_idx_d = r_idx + 3'd1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame_packer.sv
// Directed bench for uart_tx_frame_packer with a byte scoreboard.
module tb_uart_tx_frame_packer;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   n_xfer = 0;
  logic [7:0] exp_q [$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'd0;

  uart_tx_frame_packer_if bus ();

  uart_tx_frame_packer #(
    .FIFO_DEPTH (4),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected packet from a frame, built independently of the DUT.
  task automatic push_frame(input logic [41:0] f);
    logic [7:0] b [6];
    logic [7:0] x;
    b[0] = {6'b0, f[41], f[40]};
    b[1] = f[39:32];
    b[2] = f[31:24];
    b[3] = f[23:16];
    b[4] = f[15:8];
    b[5] = f[7:0];
    x = 8'd0;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(b[k]);
      x = x ^ b[k];
    end
    exp_q.push_back(x);
  endtask

  task automatic push_bytes(input logic [63:0] bytes);
    logic [63:0] v;
    v = bytes;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(v[63:56]);
      v = v << 8;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the target transfer edge.
  task automatic wait_xfers(input int target, input int budget, input bit rnd);
    int cyc;
    cyc = 0;
    while (n_xfer < target && cyc < budget) begin
      if (rnd) bus.tx_ready = ($urandom_range(0, 9) < 3);
      @(posedge clk);
      #1;
      cyc++;
    end
    total++;
    assert (n_xfer >= target)
    else begin
      bad++;
      $error("FAIL wait_xfers: observed=%0d expected=%0d", n_xfer, target);
    end
  endtask

  task automatic strobe(input logic [41:0] f);
    bus.frame_valid = 1'b1;
    bus.frame_data  = f;
    @(posedge clk);
    #1;
    bus.frame_valid = 1'b0;
  endtask

  // Transfer monitor: values at the negedge are those the next posedge will take.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.tx_valid && prev_stall) check("stall_hold", bus.tx_byte, prev_byte);
      if (bus.tx_valid && bus.tx_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL unexpected_byte: observed=%0h expected=none", bus.tx_byte);
        end else begin
          check("byte", bus.tx_byte, exp_q.pop_front());
        end
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_byte  = bus.tx_byte;
    end
  end

  initial begin
    logic [41:0] f;
    reset              = 1'b1;
    bus.frame_valid    = 1'b0;
    bus.frame_data     = '0;
    bus.tx_ready       = 1'b0;
    bus.clear_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_byte", bus.tx_byte, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_frames_sent", bus.frames_sent, 0);
    check("rst_busy", bus.busy, 0);
    reset = 1'b0;

    // Single frame and strobe-to-valid latency.
    bus.tx_ready = 1'b1;
    push_bytes(64'hA5_00_05_DE_AD_BE_EF_27);
    strobe({1'b0, 9'h005, 32'hDEADBEEF});
    check("lat_valid_n", bus.tx_valid, 0);
    check("lat_busy_n", bus.busy, 1);
    @(posedge clk);
    #1;
    check("lat_valid_n1", bus.tx_valid, 1);
    check("lat_sync_n1", bus.tx_byte, 8'hA5);
    wait_xfers(8, 50, 1'b0);
    check("t1_frames_sent", bus.frames_sent, 1);
    check("t1_busy", bus.busy, 0);

    // Boundary address and type.
    push_bytes(64'hA5_03_FF_00_00_00_00_FC);
    strobe({1'b1, 9'h1FF, 32'h0});
    wait_xfers(16, 50, 1'b0);
    check("t2_frames_sent", bus.frames_sent, 2);

    // Random backpressure.
    bus.tx_ready = 1'b0;
    push_frame({1'b1, 9'h123, 32'h89ABCDEF});
    strobe({1'b1, 9'h123, 32'h89ABCDEF});
    wait_xfers(24, 400, 1'b1);
    bus.tx_ready = 1'b1;
    check("t3_frames_sent", bus.frames_sent, 3);

    // Overflow: six frames back to back with the transmitter stalled.
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      f = {i[0], 9'(i + 64), 32'hC0DE0000 | i};
      bus.frame_valid = 1'b1;
      bus.frame_data  = f;
      if (i < 5) push_frame(f);
      // Clear on the drop cycle must lose to the set.
      bus.clear_overflow = (i == 5);
      @(posedge clk);
      #1;
      check("t4_overflow_step", bus.overflow, (i == 5) ? 1 : 0);
    end
    bus.frame_valid    = 1'b0;
    bus.clear_overflow = 1'b0;
    check("t4_busy", bus.busy, 1);
    bus.tx_ready = 1'b1;
    wait_xfers(64, 500, 1'b0);
    check("t4_overflow_sticky", bus.overflow, 1);
    check("t4_frames_sent", bus.frames_sent, 8);
    bus.clear_overflow = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_overflow = 1'b0;
    check("t4_overflow_clear", bus.overflow, 0);

    // Push and pop in the same cycle while full.
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      f = {~i[0], 9'(i * 37 + 3), 32'h5A000000 + i};
      push_frame(f);
      bus.frame_valid = 1'b1;
      bus.frame_data  = f;
      @(posedge clk);
      #1;
    end
    bus.frame_valid = 1'b0;
    check("t5_overflow_full", bus.overflow, 0);
    bus.tx_ready = 1'b1;
    wait_xfers(72, 100, 1'b0);
    f = {1'b1, 9'h0AA, 32'h13579BDF};
    push_frame(f);
    strobe(f);
    check("t5_overflow_pushpop", bus.overflow, 0);
    wait_xfers(112, 300, 1'b0);
    check("t5_frames_sent", bus.frames_sent, 14);
    check("t5_busy", bus.busy, 0);

    // Reset in the middle of a packet with another frame queued.
    bus.tx_ready = 1'b1;
    push_frame({1'b0, 9'h111, 32'hCAFEF00D});
    bus.frame_valid = 1'b1;
    bus.frame_data  = {1'b0, 9'h111, 32'hCAFEF00D};
    @(posedge clk);
    #1;
    bus.frame_data  = {1'b1, 9'h022, 32'h0BADC0DE};
    @(posedge clk);
    #1;
    bus.frame_valid = 1'b0;
    wait_xfers(116, 50, 1'b0);
    reset        = 1'b1;
    bus.tx_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t6_tx_valid", bus.tx_valid, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_frames_sent", bus.frames_sent, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("t6_idle_after", bus.tx_valid, 0);
    bus.tx_ready = 1'b1;
    f = {1'b1, 9'h0F0, 32'h76543210};
    push_frame(f);
    strobe(f);
    wait_xfers(124, 50, 1'b0);
    check("t6_frames_sent_new", bus.frames_sent, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
